// File: rtl/fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module   : fibonacci_checker
// Brief    : Locks onto a Fibonacci stream at a 0 term and checks each later
//            beat. Optional FIBCHK_INDEX_EN builds the term-index counter.
// Revision : 1.0
// ============================================================================
module fibonacci_checker #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_match,
  output logic             out_locked,
  output logic [IDX_W-1:0] out_index,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [0:0] STATE_HUNT = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] exp_prev_q, exp_prev_d;
  logic [WIDTH-1:0] exp_cur_q, exp_cur_d;
  logic             out_valid_q, out_valid_d;
  logic             out_match_q, out_match_d;
  logic             out_locked_q, out_locked_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic w_accept;
  logic w_eff_run;
  logic w_is_zero;
  logic w_exp_hit;
  logic w_wrap;
  logic w_err_sat;

  assign in_ready  = !out_valid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  // clear forces the beat accepted in the same cycle to be judged as in HUNT
  assign w_eff_run = (state_q == STATE_RUN) && !clear;
  assign w_is_zero = (in_value == '0);
  assign w_exp_hit = (in_value == exp_prev_q);
  assign w_wrap    = exp_cur_q[WIDTH-1];
  assign w_err_sat = &err_count_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STATE_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: any accepted 0 (locking or relocking) or a hit keeps RUN
  always_comb begin
    state_d = state_q;
    if (w_accept) begin
      state_d = ((w_eff_run && w_exp_hit) || w_is_zero) ? STATE_RUN : STATE_HUNT;
    end else if (clear) begin
      state_d = STATE_HUNT;
    end
  end

  // Verdict and model update
  always_comb begin
    out_valid_d  = out_valid_q;
    out_match_d  = out_match_q;
    out_locked_d = out_locked_q;
    exp_prev_d   = exp_prev_q;
    exp_cur_d    = exp_cur_q;
    err_count_d  = err_count_q;

    if (w_accept) begin
      out_valid_d = 1'b1;
      if (!w_eff_run) begin
        out_match_d  = w_is_zero;
        out_locked_d = w_is_zero;
        if (w_is_zero) begin
          exp_prev_d = {{(WIDTH-1){1'b0}}, 1'b1};
          exp_cur_d  = {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end else if (w_exp_hit) begin
        out_match_d  = 1'b1;
        out_locked_d = 1'b1;
        // Successor would set the MSB: restart the sequence at 0
        if (w_wrap) begin
          exp_prev_d = '0;
          exp_cur_d  = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          exp_prev_d = exp_cur_q;
          exp_cur_d  = exp_prev_q + exp_cur_q;
        end
      end else begin
        out_match_d  = 1'b0;
        out_locked_d = w_is_zero;
        if (!w_err_sat) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (w_is_zero) begin
          exp_prev_d = {{(WIDTH-1){1'b0}}, 1'b1};
          exp_cur_d  = {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_prev_q   <= '0;
      exp_cur_q    <= '0;
      out_valid_q  <= 1'b0;
      out_match_q  <= 1'b0;
      out_locked_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      exp_prev_q   <= exp_prev_d;
      exp_cur_q    <= exp_cur_d;
      out_valid_q  <= out_valid_d;
      out_match_q  <= out_match_d;
      out_locked_q <= out_locked_d;
      err_count_q  <= err_count_d;
    end
  end

`ifdef FIBCHK_INDEX_EN
  logic [IDX_W-1:0] index_q, index_d;

  // A hit on an expected 0 (post-wrap) restarts the index like a lock does
  always_comb begin
    index_d = index_q;
    if (w_accept) begin
      if (w_eff_run && w_exp_hit && (exp_prev_q != '0)) begin
        index_d = index_q + 1'b1;
      end else begin
        index_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign out_index = index_q;
`else
  assign out_index = '0;
`endif

  assign out_valid  = out_valid_q;
  assign out_match  = out_match_q;
  assign out_locked = out_locked_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fibonacci_checker
// Brief    : Directed self-checking bench for fibonacci_checker (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_fibonacci_checker;

  localparam int WIDTH = 8;
  localparam int IDX_W = 6;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_value = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_match;
  logic             out_locked;
  logic [IDX_W-1:0] out_index;
  logic [ERR_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  fibonacci_checker #(.WIDTH(WIDTH), .IDX_W(IDX_W), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_match  (out_match),
    .out_locked (out_locked),
    .out_index  (out_index),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected index depends on whether the index counter is built
  function automatic int eidx(input int i);
`ifdef FIBCHK_INDEX_EN
    return i;
`else
    return i * 0;
`endif
  endfunction

  // One accepted beat with out_ready=1, verdict checked one cycle later
  task automatic send(input string tag, input logic [WIDTH-1:0] v, input bit m,
                      input bit l, input int idx, input int err);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_value  = v;
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".valid"},  out_valid,  1);
    check({tag, ".match"},  out_match,  m);
    check({tag, ".locked"}, out_locked, l);
    check({tag, ".index"},  out_index,  eidx(idx));
    check({tag, ".err"},    err_count,  err);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  logic [WIDTH-1:0] fib [12] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5,
                                 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89};

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",    out_valid,  0);
    check("rst.match",    out_match,  0);
    check("rst.locked",   out_locked, 0);
    check("rst.index",    out_index,  0);
    check("rst.err",      err_count,  0);
    check("rst.in_ready", in_ready,   1);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: full sequence to 89, wrap to 0, then 1
    for (int i = 0; i < 12; i++) send("t1.seq", fib[i], 1, 1, i, 0);
    send("t1.wrap0", 8'd0, 1, 1, 0, 0);
    send("t1.wrap1", 8'd1, 1, 1, 1, 0);

    // 2: bad term drops to HUNT, nonzero in HUNT is not counted, 0 relocks
    clear_pulse();
    for (int i = 0; i < 4; i++) send("t2.seq", fib[i], 1, 1, i, 0);
    send("t2.bad4",  8'd4, 0, 0, 0, 1);
    send("t2.hunt7", 8'd7, 0, 0, 0, 1);
    send("t2.lock0", 8'd0, 1, 1, 0, 1);

    // 3: unexpected 0 in RUN relocks in the same cycle
    clear_pulse();
    for (int i = 0; i < 4; i++) send("t3.seq", fib[i], 1, 1, i, 0);
    send("t3.relock", 8'd0, 0, 1, 0, 1);
    send("t3.next1",  8'd1, 1, 1, 1, 1);

    // 4: backpressure for 3 cycles with in_valid held high
    clear_pulse();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_value  = 8'd0;
    @(posedge clk);
    #1;
    in_value = 8'd1;
    check("t4.first.valid",    out_valid, 1);
    check("t4.first.match",    out_match, 1);
    check("t4.first.index",    out_index, eidx(0));
    check("t4.first.in_ready", in_ready,  0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("t4.hold.in_ready", in_ready,  0);
      check("t4.hold.valid",    out_valid, 1);
      check("t4.hold.match",    out_match, 1);
      check("t4.hold.index",    out_index, eidx(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4.rel1.match", out_match, 1);
    check("t4.rel1.index", out_index, eidx(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t4.rel2.match", out_match, 1);
    check("t4.rel2.index", out_index, eidx(2));
    send("t4.next2", 8'd2, 1, 1, 3, 0);

    // 5: error counter saturation, then clear returns to HUNT with zero count
    clear_pulse();
    send("t5.lock", 8'd0, 1, 1, 0, 0);
    for (int i = 0; i < 300; i++) send("t5.relock", 8'd0, 0, 1, 0, (i + 1 > 255) ? 255 : i + 1);
    clear_pulse();
    check("t5.cleared", err_count, 0);
    send("t5.hunt5", 8'd5, 0, 0, 0, 0);

    // 6: async reset with a pending verdict
    send("t6.lock", 8'd0, 1, 1, 0, 0);
    send("t6.one",  8'd1, 1, 1, 1, 0);
    send("t6.bad",  8'd9, 0, 0, 0, 1);
    send("t6.lk2",  8'd0, 1, 1, 0, 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_value  = 8'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t6.pending", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6.rst.valid",  out_valid,  0);
    check("t6.rst.locked", out_locked, 0);
    check("t6.rst.err",    err_count,  0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send("t6.relock", 8'd0, 1, 1, 0, 0);
    send("t6.after",  8'd1, 1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
